// File: rtl/sw_debounce_sync.sv
// Switch conditioner: 2-flop synchroniser, tick prescaler and per-bit debounce counters.
// Produces a registered debounced bus, one-cycle rise/fall strobes and a ready flag.
module sw_debounce_sync #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned STABLE_CNT = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change,
    output logic             ready
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;

    logic [WIDTH-1:0]         s1_q;
    logic [WIDTH-1:0]         s2_q;
    logic [PW-1:0]            presc_q, presc_d;
    logic                     tick_c;
    logic [CW-1:0]            init_cnt_q, init_cnt_d;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]         sw_db_q, sw_db_d;
    logic [WIDTH-1:0]         rise_q, rise_d;
    logic [WIDTH-1:0]         fall_q, fall_d;
    logic                     any_change_q, any_change_d;
    logic                     ready_q, ready_d;

    // Free-running sample prescaler; tick marks the terminal count.
    always_comb begin
        tick_c  = (presc_q == PW'(TICK_DIV - 1));
        presc_d = tick_c ? '0 : presc_q + PW'(1);
    end

    // Init preload while not ready, per-bit debounce afterwards; everything advances on tick only.
    always_comb begin
        init_cnt_d = init_cnt_q;
        cnt_d      = cnt_q;
        sw_db_d    = sw_db_q;
        rise_d     = '0;
        fall_d     = '0;
        ready_d    = ready_q;
        if (tick_c) begin
            if (!ready_q) begin
                if (init_cnt_q == CW'(STABLE_CNT - 1)) begin
                    sw_db_d    = s2_q;
                    ready_d    = 1'b1;
                    cnt_d      = '0;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + CW'(1);
                end
            end else begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (s2_q[i] == sw_db_q[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == CW'(STABLE_CNT - 1)) begin
                        sw_db_d[i] = s2_q[i];
                        cnt_d[i]   = '0;
                        rise_d[i]  = s2_q[i];
                        fall_d[i]  = ~s2_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
            end
        end
        any_change_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= '0;
            s2_q         <= '0;
            presc_q      <= '0;
            init_cnt_q   <= '0;
            cnt_q        <= '0;
            sw_db_q      <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            any_change_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            s1_q         <= sw;
            s2_q         <= s1_q;
            presc_q      <= presc_d;
            init_cnt_q   <= init_cnt_d;
            cnt_q        <= cnt_d;
            sw_db_q      <= sw_db_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            any_change_q <= any_change_d;
            ready_q      <= ready_d;
        end
    end

    assign sw_db      = sw_db_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign any_change = any_change_q;
    assign ready      = ready_q;

endmodule
